// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Brief   : PS/2 host-to-device byte transmitter driving open-drain line enables.
// Rev     : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 975000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] C_IDLE      = 3'd0;
  localparam logic [2:0] C_INHIBIT   = 3'd1;
  localparam logic [2:0] C_START     = 3'd2;
  localparam logic [2:0] C_SEND      = 3'd3;
  localparam logic [2:0] C_ACK       = 3'd4;
  localparam logic [2:0] C_WAIT_IDLE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_cnt_q, edge_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             data_s1_q, data_s2_q;

  logic accept, fall, in_timed, timeout_hit, inhibit_end, edge_ev, idle_seen;

  assign tx_ready    = (state_q == C_IDLE) && !rst;
  assign busy        = (state_q != C_IDLE);
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

  assign accept      = tx_valid && tx_ready;
  assign fall        = clk_prev_q && !clk_s2_q;
  assign in_timed    = (state_q == C_START) || (state_q == C_SEND) ||
                       (state_q == C_ACK)   || (state_q == C_WAIT_IDLE);
  assign timeout_hit = in_timed && (cnt_q == C_TMO_LAST);
  assign inhibit_end = (state_q == C_INHIBIT) && (cnt_q == C_INH_LAST);
  // Edges are only meaningful while the device is clocking our frame in.
  assign edge_ev     = fall && ((state_q == C_SEND) || (state_q == C_ACK)) && !timeout_hit;
  assign idle_seen   = clk_s2_q && data_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= C_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= 4'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = C_IDLE;
    end else begin
      case (state_q)
        C_IDLE:      if (accept) state_d = C_INHIBIT;
        C_INHIBIT:   if (inhibit_end) state_d = C_START;
        C_START:     state_d = C_SEND;
        C_SEND:      if (edge_ev && (edge_cnt_q == 4'd9)) state_d = C_ACK;
        C_ACK:       if (edge_ev) state_d = data_s2_q ? C_IDLE : C_WAIT_IDLE;
        C_WAIT_IDLE: if (idle_seen) state_d = C_IDLE;
        default:     state_d = C_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    if (timeout_hit) begin
      cnt_d      = '0;
      edge_cnt_d = 4'd0;
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      error_d    = 1'b1;
    end else begin
      case (state_q)
        C_IDLE: begin
          cnt_d      = '0;
          edge_cnt_d = 4'd0;
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          if (accept) begin
            shift_d  = tx_data;
            parity_d = ~(^tx_data);
            clk_oe_d = 1'b1;
          end
        end
        C_INHIBIT: begin
          if (inhibit_end) begin
            cnt_d     = '0;
            data_oe_d = 1'b1;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
        C_START: begin
          cnt_d    = cnt_q + C_CNT_ONE;
          clk_oe_d = 1'b0;
        end
        C_SEND: begin
          cnt_d = cnt_q + C_CNT_ONE;
          if (edge_ev) begin
            edge_cnt_d = edge_cnt_q + 4'd1;
            // A driven-low line sends 0, so the enable is the inverted bit.
            if (edge_cnt_q < 4'd8) begin
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b0, shift_q[7:1]};
            end else if (edge_cnt_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;
            end
          end
        end
        C_ACK: begin
          cnt_d = cnt_q + C_CNT_ONE;
          if (edge_ev && data_s2_q) error_d = 1'b1;
        end
        C_WAIT_IDLE: begin
          cnt_d = cnt_q + C_CNT_ONE;
          if (idle_seen) done_d = 1'b1;
        end
        default: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 6500, clock-low inhibit time (100 us at 65 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 975000, maximum cycles from end of inhibit to ack (15 ms at 65 MHz).
REQ-003 SHALL have port clk, input, 1, the single system clock (clk65MHz domain); all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port tx_data, input, 8, the command byte to send to the mouse.
REQ-006 SHALL have port tx_valid, input, 1, the send request.
REQ-007 SHALL have port tx_ready, output, 1, high when a new byte can be accepted.
REQ-008 SHALL have port tx_done, output, 1, a one-cycle pulse on a successful acked transfer.
REQ-009 SHALL have port tx_error, output, 1, a one-cycle pulse on no-ack or timeout.
REQ-010 SHALL have port busy, output, 1, high from acceptance until return to IDLE; the receiver ignores the bus while it is high.
REQ-011 SHALL have port ps2_clk_in, input, 1, the raw PS/2 clock line level (asynchronous).
REQ-012 SHALL have port ps2_data_in, input, 1, the raw PS/2 data line level (asynchronous).
REQ-013 SHALL have port ps2_clk_oe, output, 1; when 1 the top level drives ps2_clk low, otherwise it is released (Z).
REQ-014 SHALL have port ps2_data_oe, output, 1; when 1 the top level drives ps2_data low, otherwise it is released (Z).

Function
REQ-015 SHALL pass ps2_clk_in and ps2_data_in through a 2-flop synchronizer each.
- A falling edge is previous synced clk = 1 and current synced clk = 0.
REQ-016 SHALL accept a byte on the cycle where tx_valid && tx_ready.
- Latches tx_data and computes parity = ~^tx_data (odd parity).
- tx_valid is ignored whenever tx_ready = 0.
REQ-017 SHALL implement the states IDLE, INHIBIT, START, SEND, ACK and WAIT_IDLE.
REQ-018 IDLE behaviour:
- tx_ready = 1, busy = 0, both oe = 0.
- Goes to INHIBIT on acceptance.
- tx_ready = 0 and busy = 1 from the next cycle.
REQ-019 INHIBIT behaviour:
- ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, ps2_data_oe = 0.
- Then goes to START.
REQ-020 START behaviour:
- Lasts one cycle with ps2_clk_oe = 1 and ps2_data_oe = 1 (start bit 0).
- Then goes to SEND with ps2_clk_oe = 0 and ps2_data_oe held at 1.
REQ-021 SEND uses a 4-bit counter of falling edges:
- Edges 1-8 set ps2_data_oe = ~tx_data[edge-1] (LSB first), registered the cycle after detection.
- Edge 9 sets ps2_data_oe = ~parity.
- Edge 10 sets ps2_data_oe = 0 (stop bit 1), then goes to ACK.
REQ-022 ACK behaviour:
- On the 11th falling edge, samples synced data.
- 0 goes to WAIT_IDLE; 1 pulses tx_error and goes to IDLE.
REQ-023 WAIT_IDLE behaviour:
- Waits until synced clk = 1 and synced data = 1 together.
- Then pulses tx_done and goes to IDLE.
REQ-024 SHALL detect edges only in SEND and ACK; edges elsewhere are ignored, including the line release after START.
REQ-025 Timeout handling:
- A timeout counter runs from START through WAIT_IDLE.
- Reaching TIMEOUT_CYCLES releases both oe the same cycle, pulses tx_error and goes to IDLE.
- Timeout takes priority over a simultaneous edge.
REQ-026 SHALL never assert tx_done and tx_error in the same cycle.
REQ-027 SHALL have ps2_clk_oe and ps2_data_oe as direct register outputs (glitch-free).

Reset
REQ-028 While rst = 1:
- State = IDLE and all counters = 0.
- ps2_clk_oe = 0, ps2_data_oe = 0, tx_done = 0, tx_error = 0, busy = 0.
- tx_ready = 0 during reset, 1 from the first cycle after reset is deasserted.
REQ-029 SHALL abort a transfer when rst is asserted mid-transfer:
- Lines are released on the next clock edge.
- No tx_done or tx_error pulse is generated.

Verification
REQ-030 Send 0xF4 with device model ack:
- Clock held low for 6500 cycles, then start bit.
- Bits on edges 1-8 = 0,0,1,0,1,1,1,1; parity = 0; stop = 1.
- Ack = 0, then tx_done pulses once and tx_ready = 1.
REQ-031 Send 0xFF: parity bit on edge 9 = 1; full transfer ends with tx_done.
REQ-032 Device holds data high at edge 11 -> tx_error pulse, no tx_done, both oe = 0, state IDLE.
REQ-033 Device never clocks after START -> tx_error exactly TIMEOUT_CYCLES cycles after START, lines released.
REQ-034 Pulse tx_valid with 0x00 during SEND of 0xF4 -> ignored; the byte on the wire remains 0xF4.
REQ-035 Assert rst after edge 5 -> both oe = 0 next cycle, no done/error pulse, a later 0xF4 transfer completes normally.
